// File: rtl/axi_read_bridge.sv
// AXI4-Lite read bridge behind the 3-port request arbiter.
// Each accepted request becomes a single-beat 64-bit AXI read. The addressed
// byte, half, word or dword is extracted from the beat and sign- or
// zero-extended. A misaligned access gets an error response without any bus
// traffic. An aborted request still drains its bus transaction, but no Done
// pulse is produced for it.
module axi_read_bridge #(
  parameter int ADDR_WIDTH      = 56,
  parameter int DATA_WIDTH      = 64,
  parameter int DATA_TYPE_WIDTH = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       Req_Valid,
  input  logic [ADDR_WIDTH-1:0]      Req_Addr,
  input  logic [DATA_TYPE_WIDTH-1:0] Req_DataType,
  input  logic                       Req_Abort,
  output logic                       Resp_Done,
  output logic                       Resp_Ready,
  output logic [DATA_WIDTH-1:0]      Resp_Data,
  output logic                       Resp_Err,
  output logic [ADDR_WIDTH-1:0]      m_araddr,
  output logic [2:0]                 m_arsize,
  output logic                       m_arvalid,
  input  logic                       m_arready,
  input  logic [DATA_WIDTH-1:0]      m_rdata,
  input  logic [1:0]                 m_rresp,
  input  logic                       m_rvalid,
  output logic                       m_rready
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t                     state_q;
  logic                       killed_q;
  logic [2:0]                 off_q;
  logic [DATA_TYPE_WIDTH-1:0] dtype_q;
  logic [DATA_WIDTH-1:0]      ext_d;

  // An access is aligned when the byte offset is a multiple of its size.
  function automatic logic misaligned(input logic [2:0] off, input logic [1:0] sz);
    case (sz)
      2'd0:    return 1'b0;
      2'd1:    return off[0];
      2'd2:    return |off[1:0];
      default: return |off;
    endcase
  endfunction

  // Shift the addressed lane down to bit 0, then extend it to the full width.
  function automatic logic [DATA_WIDTH-1:0] extract(input logic [DATA_WIDTH-1:0] rdata,
                                                    input logic [2:0]            off,
                                                    input logic [1:0]            sz,
                                                    input logic                  zext);
    logic [DATA_WIDTH-1:0] sh;
    logic signed [7:0]     b;
    logic signed [15:0]    h;
    logic signed [31:0]    w;
    logic signed [63:0]    s;
    sh = rdata >> {off, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    w  = sh[31:0];
    case (sz)
      2'd0:    s = zext ? 64'(sh[7:0])  : 64'(b);
      2'd1:    s = zext ? 64'(sh[15:0]) : 64'(h);
      2'd2:    s = zext ? 64'(sh[31:0]) : 64'(w);
      default: s = sh;
    endcase
    return s;
  endfunction

  // Load result for the current beat, using the latched offset and type.
  always_comb begin
    ext_d = extract(m_rdata, off_q, dtype_q[1:0], dtype_q[2]);
  end

  // Only 8-byte beats are ever requested.
  assign m_arsize = 3'b011;

  // Request FSM; every response and AXI control output is registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      killed_q   <= 1'b0;
      off_q      <= 3'd0;
      dtype_q    <= '0;
      m_araddr   <= '0;
      m_arvalid  <= 1'b0;
      m_rready   <= 1'b0;
      Resp_Done  <= 1'b0;
      Resp_Ready <= 1'b1;
      Resp_Data  <= '0;
      Resp_Err   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Req_Valid && !Req_Abort) begin
            off_q      <= Req_Addr[2:0];
            dtype_q    <= Req_DataType;
            killed_q   <= 1'b0;
            Resp_Ready <= 1'b0;
            if (misaligned(Req_Addr[2:0], Req_DataType[1:0])) begin
              state_q   <= RESP;
              Resp_Done <= 1'b1;
              Resp_Err  <= 1'b1;
              Resp_Data <= '0;
            end else begin
              state_q   <= ADDR;
              m_araddr  <= {Req_Addr[ADDR_WIDTH-1:3], 3'b000};
              m_arvalid <= 1'b1;
            end
          end
        end
        ADDR: begin
          // AR stays up once raised, even after an abort.
          if (Req_Abort) killed_q <= 1'b1;
          if (m_arready) begin
            m_arvalid <= 1'b0;
            m_rready  <= 1'b1;
            state_q   <= DATA;
          end
        end
        DATA: begin
          if (Req_Abort) killed_q <= 1'b1;
          if (m_rvalid) begin
            m_rready <= 1'b0;
            if (killed_q || Req_Abort) begin
              // Beat drained for a cancelled request: no response.
              state_q    <= IDLE;
              Resp_Ready <= 1'b1;
            end else begin
              state_q   <= RESP;
              Resp_Done <= 1'b1;
              Resp_Data <= ext_d;
              Resp_Err  <= (m_rresp != 2'b00);
            end
          end
        end
        RESP: begin
          state_q    <= IDLE;
          Resp_Done  <= 1'b0;
          Resp_Data  <= '0;
          Resp_Err   <= 1'b0;
          Resp_Ready <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
